uart_tx_arbiter: RTL and testbench



---
 rtl/uart_arb_pkg.sv | 45 ++++
 rtl/uart_tx_arbiter_if.sv | 34 +++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 50 +++++
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and helpers for the UART transmit arbiter and its reusable
// round-robin core.
//   state_e        : arbiter FSM states (IDLE, START, WAIT)
//   MAX_REQ        : widest requester vector rr_pick handles (8)
//   TIMEOUT_W_DEF  : default watchdog counter width
//   WD_MAX_DEF     : watchdog expiry value at the default width (all ones)
//   rr_pick()      : one-hot round-robin winner, search starts after pointer
// ---------------------------------------------------------------------------
package uart_arb_pkg;

  localparam int MAX_REQ       = 8;
  localparam int TIMEOUT_W_DEF = 20;
  localparam logic [TIMEOUT_W_DEF-1:0] WD_MAX_DEF = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;

  // Pointer holds the last granted index, so the search begins at ptr+1 and
  // ends at ptr itself; that way a lone requester is re-granted every time.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input logic [2:0]         ptr,
                                                  input int unsigned        n);
    logic [MAX_REQ-1:0] win;
    logic               found;
    int unsigned        idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      if (i <= n && !found) begin
        idx = (32'(ptr) + i) % n;
        if (valid[idx[2:0]]) begin
          win[idx[2:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester-side byte streams and the UART core transmit side.
//   req_valid_i / req_data_i / req_last_i / req_ready_o : N_REQ byte streams
//   tx_data_o / tx_en_o / tx_done_i                     : UART core tx side
//   busy_o / grant_o / timeout_o                        : status
// Modports:
//   master : requesters + UART core (drive the *_i signals)
//   slave  : the arbiter (drives the *_o signals)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid_i;
  logic [8*N_REQ-1:0] req_data_i;
  logic [N_REQ-1:0]   req_last_i;
  logic [N_REQ-1:0]   req_ready_o;
  logic [7:0]         tx_data_o;
  logic               tx_en_o;
  logic               tx_done_i;
  logic               busy_o;
  logic [N_REQ-1:0]   grant_o;
  logic               timeout_o;

  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_done_i,
    input  req_ready_o, tx_data_o, tx_en_o, busy_o, grant_o, timeout_o
  );

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, tx_done_i,
    output req_ready_o, tx_data_o, tx_en_o, busy_o, grant_o, timeout_o
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Generic round-robin arbiter: combinational rotate-priority pick plus the
// registered "last granted" pointer. Meant for reuse on other shared
// peripherals.
//   clk_i, rst_i : clock, synchronous active-high reset (pointer -> 0)
//   req_i        : N request lines
//   ptr_load_i   : commit ptr_i as the new last-granted index
//   ptr_i        : index to commit
//   gnt_o        : one-hot winner (zero when no request)
//   gnt_idx_o    : binary index of gnt_o
// ---------------------------------------------------------------------------
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          ptr_load_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [MAX_REQ-1:0] win;

  always_comb begin
    win       = rr_pick(MAX_REQ'(req_i), 3'(ptr_q), N);
    gnt_o     = win[N-1:0];
    gnt_idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_o[i]) gnt_idx_o = IW'(i);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (ptr_load_i) ptr_d = ptr_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between N_REQ byte-stream requesters using
// round-robin arbitration, one frame in flight at a time, with a tx_done
// watchdog.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : requester streams, UART tx side, busy/grant/timeout status
// Optional build macro UART_ARB_PKT_LOCK_EN: hold the grant on one requester
// until it sends a byte flagged req_last_i (or the watchdog fires), so packets
// never interleave. Without it req_last_i is ignored.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input logic               clk_i,
  input logic               rst_i,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

  state_e               state_q, state_d;
  logic [7:0]           data_q, data_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 timeout_q, timeout_d;
  logic [IW-1:0]        owner_q, owner_d;

  logic [N_REQ-1:0]     cand;
  logic [N_REQ-1:0]     pick;
  logic [IW-1:0]        pick_idx;
  logic                 ptr_load;
  logic [N_REQ-1:0]     ready;
  logic [N_REQ-1:0]     grant_out;

`ifdef UART_ARB_PKT_LOCK_EN
  logic lock_q, lock_d;
  // While locked only the owner of the open packet may win.
  assign cand = lock_q ? (bus.req_valid_i & (N_REQ'(1) << owner_q)) : bus.req_valid_i;
`else
  logic unused_last;
  assign unused_last = ^bus.req_last_i;
  assign cand        = bus.req_valid_i;
`endif

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (cand),
    .ptr_load_i (ptr_load),
    .ptr_i      (owner_q),
    .gnt_o      (pick),
    .gnt_idx_o  (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    grant_d   = grant_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    owner_d   = owner_q;
    ptr_load  = 1'b0;
    ready     = '0;
    grant_out = grant_q;
`ifdef UART_ARB_PKT_LOCK_EN
    lock_d    = lock_q;
`endif
    case (state_q)
      IDLE: begin
        // No acceptance while reset is held, so outputs stay zero during it.
        if (|cand && !rst_i) begin
          ready     = pick;
          grant_d   = pick;
          grant_out = pick;
          owner_d   = pick_idx;
          data_d    = bus.req_data_i[int'(pick_idx)*8 +: 8];
          state_d   = START;
`ifdef UART_ARB_PKT_LOCK_EN
          lock_d    = !bus.req_last_i[pick_idx];
`endif
        end
      end
      START: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + TIMEOUT_W'(1);
        // A done arriving on the expiry cycle wins over the timeout.
        if (bus.tx_done_i) begin
          ptr_load = 1'b1;
          state_d  = IDLE;
        end else if (wd_d == WD_MAX) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
`ifdef UART_ARB_PKT_LOCK_EN
          lock_d    = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      data_q    <= '0;
      grant_q   <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      owner_q   <= '0;
`ifdef UART_ARB_PKT_LOCK_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      grant_q   <= grant_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      owner_q   <= owner_d;
`ifdef UART_ARB_PKT_LOCK_EN
      lock_q    <= lock_d;
`endif
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.grant_o     = grant_out;
  assign bus.tx_data_o   = data_q;
  assign bus.tx_en_o     = (state_q == START);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.timeout_o   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (N_REQ = 4, TIMEOUT_W = 4).
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(4)) bus ();

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $fatal(1, "FAIL global_timeout observed=running expected=finished");
  end

  initial begin
    int ord_rr [5];
    int ord_lk [5];
    int b2;
    int k;
    logic [7:0] expd;

    ord_rr = '{1, 2, 3, 0, 1};
`ifdef UART_ARB_PKT_LOCK_EN
    ord_lk = '{2, 2, 2, 0, 0};
`else
    ord_lk = '{2, 0, 2, 0, 2};
`endif

    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.req_last_i  = '0;
    bus.tx_done_i   = 1'b0;

    // reset state
    cyc();
    cyc();
    check("rst_busy",  32'(bus.busy_o),      0);
    check("rst_txen",  32'(bus.tx_en_o),     0);
    check("rst_ready", 32'(bus.req_ready_o), 0);
    check("rst_grant", 32'(bus.grant_o),     0);
    check("rst_tmo",   32'(bus.timeout_o),   0);
    check("rst_data",  32'(bus.tx_data_o),   0);
    rst = 1'b0;

    // single requester: accept cycle 0, tx_en cycle 1, done at cycle 11
    bus.req_valid_i = 4'b0001;
    bus.req_data_i  = 32'h0000_0055;
    #1;
    check("t1_ready", 32'(bus.req_ready_o), 32'h1);
    check("t1_grant", 32'(bus.grant_o),     32'h1);
    cyc();
    bus.req_valid_i = '0;
    check("t1_txen",  32'(bus.tx_en_o),     1);
    check("t1_data",  32'(bus.tx_data_o),   32'h55);
    check("t1_busy1", 32'(bus.busy_o),      1);
    check("t1_rdy_st",32'(bus.req_ready_o), 0);
    for (int c = 2; c <= 10; c++) begin
      cyc();
      check("t1_wait_busy", 32'(bus.busy_o),  1);
      check("t1_wait_txen", 32'(bus.tx_en_o), 0);
    end
    cyc();
    bus.tx_done_i = 1'b1;
    check("t1_busy11", 32'(bus.busy_o), 1);
    cyc();
    bus.tx_done_i = 1'b0;
    check("t1_idle",   32'(bus.busy_o),    0);
    check("t1_hold",   32'(bus.tx_data_o), 32'h55);
    check("t1_owner",  32'(bus.grant_o),   32'h1);

    // all four valid: grants 1,2,3,0,1
    bus.req_valid_i = 4'b1111;
    bus.req_data_i  = 32'hA3A2_A1A0;
    #1;
    for (int f = 0; f < 5; f++) begin
      check("rr_ready", 32'(bus.req_ready_o), 32'(1) << ord_rr[f]);
      check("rr_grant", 32'(bus.grant_o),     32'(1) << ord_rr[f]);
      cyc();
      check("rr_txen",  32'(bus.tx_en_o),   1);
      check("rr_data",  32'(bus.tx_data_o), 32'(8'hA0 + 8'(ord_rr[f])));
      cyc();
      check("rr_txen_wait", 32'(bus.tx_en_o),     0);
      check("rr_rdy_wait",  32'(bus.req_ready_o), 0);
      bus.tx_done_i = 1'b1;
      cyc();
      bus.tx_done_i = 1'b0;
      #1;
    end
    bus.req_valid_i = '0;
    #1;

    // spurious tx_done in IDLE and START (pointer now 1)
    bus.tx_done_i = 1'b1;
    cyc();
    bus.tx_done_i = 1'b0;
    check("sp_idle", 32'(bus.busy_o), 0);
    bus.req_valid_i = 4'b1000;
    bus.req_data_i  = 32'h3C00_0000;
    #1;
    check("sp_ready", 32'(bus.req_ready_o), 32'h8);
    cyc();
    bus.req_valid_i = '0;
    bus.tx_done_i   = 1'b1;
    check("sp_txen", 32'(bus.tx_en_o), 1);
    cyc();
    bus.tx_done_i = 1'b0;
    check("sp_wait_busy", 32'(bus.busy_o),  1);
    check("sp_wait_txen", 32'(bus.tx_en_o), 0);
    cyc();
    check("sp_still_wait", 32'(bus.busy_o), 1);
    bus.tx_done_i = 1'b1;
    cyc();
    bus.tx_done_i = 1'b0;
    check("sp_done_idle", 32'(bus.busy_o), 0);

    // watchdog: 15 WAIT cycles without done (pointer 3 -> req 2 wins)
    bus.req_valid_i = 4'b0100;
    bus.req_data_i  = 32'h0077_0000;
    #1;
    check("wd_ready", 32'(bus.req_ready_o), 32'h4);
    cyc();
    bus.req_valid_i = '0;
    check("wd_txen", 32'(bus.tx_en_o), 1);
    cyc();
    for (int n = 1; n <= 14; n++) begin
      check("wd_busy",  32'(bus.busy_o),    1);
      check("wd_notmo", 32'(bus.timeout_o), 0);
      cyc();
    end
    check("wd_busy15",  32'(bus.busy_o),    1);
    check("wd_notmo15", 32'(bus.timeout_o), 0);
    cyc();
    check("wd_tmo",  32'(bus.timeout_o), 1);
    check("wd_idle", 32'(bus.busy_o),    0);
    for (int n = 0; n < 3; n++) begin
      cyc();
      check("wd_sticky", 32'(bus.timeout_o), 1);
    end

    // reset mid-WAIT; pointer 3 (untouched by timeout) -> req 1 wins
    bus.req_valid_i = 4'b0010;
    bus.req_data_i  = 32'h0000_1100;
    #1;
    check("mr_ready", 32'(bus.req_ready_o), 32'h2);
    cyc();
    bus.req_valid_i = '0;
    cyc();
    cyc();
    check("mr_busy", 32'(bus.busy_o), 1);
    bus.req_valid_i = 4'b1001;
    bus.req_data_i  = 32'h3C00_000A;
    rst = 1'b1;
    cyc();
    check("mr_busy0",  32'(bus.busy_o),      0);
    check("mr_txen0",  32'(bus.tx_en_o),     0);
    check("mr_ready0", 32'(bus.req_ready_o), 0);
    check("mr_grant0", 32'(bus.grant_o),     0);
    check("mr_tmo0",   32'(bus.timeout_o),   0);
    check("mr_data0",  32'(bus.tx_data_o),   0);
    rst = 1'b0;
    #1;
    // pointer back at 0, so the search starts at 1 and finds 3 before 0
    check("mr_reacc", 32'(bus.req_ready_o), 32'h8);
    cyc();
    bus.req_valid_i = 4'b0001;
    check("mr_txen",  32'(bus.tx_en_o),   1);
    check("mr_data",  32'(bus.tx_data_o), 32'h3C);
    cyc();
    bus.tx_done_i = 1'b1;
    cyc();
    bus.tx_done_i = 1'b0;
    #1;
    check("mr_next", 32'(bus.req_ready_o), 32'h1);
    cyc();
    bus.req_valid_i = '0;
    check("mr_data2", 32'(bus.tx_data_o), 32'h0A);

    // done on the same cycle the watchdog would expire: no timeout
    cyc();
    for (int n = 1; n <= 14; n++) cyc();
    bus.tx_done_i = 1'b1;
    cyc();
    bus.tx_done_i = 1'b0;
    check("de_notmo", 32'(bus.timeout_o), 0);
    check("de_idle",  32'(bus.busy_o),    0);

    // packet test: req 2 sends 3 bytes (last on 3rd), req 0 valid throughout
    b2 = 0;
    bus.req_valid_i = 4'b0101;
    bus.req_data_i  = 32'h00C0_000B;
    bus.req_last_i  = 4'b0000;
    #1;
    for (int f = 0; f < 5; f++) begin
      k    = ord_lk[f];
      expd = (k == 2) ? (8'hC0 + 8'(b2)) : 8'h0B;
      check("pk_ready", 32'(bus.req_ready_o), 32'(1) << k);
      cyc();
      check("pk_txen", 32'(bus.tx_en_o),   1);
      check("pk_data", 32'(bus.tx_data_o), 32'(expd));
      if (k == 2) begin
        b2++;
        if (b2 == 3) begin
          bus.req_valid_i[2] = 1'b0;
          bus.req_last_i[2]  = 1'b0;
        end else begin
          bus.req_data_i[23:16] = 8'hC0 + 8'(b2);
          bus.req_last_i[2]     = (b2 == 2);
        end
      end
      cyc();
      bus.tx_done_i = 1'b1;
      cyc();
      bus.tx_done_i = 1'b0;
      #1;
    end
    bus.req_valid_i = '0;
    #1;
    check("end_tmo", 32'(bus.timeout_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
